memory_cmd_sched: RTL and testbench

Command scheduler and round sequencer for the memory-game datapath.
- Sits between the board push-buttons and the game state machine.
- Turns raw button levels into debounced, single-cycle, mutually exclusive move and select commands.
- Starts and restarts the game and holds off commands during a timed board-reveal phase at the start of every round.
- Decides when the game datapath may accept player input; the game FSM itself stays purely reactive.

---
 rtl/memory_cmd_sched.sv | 166 ++++++++++++++++
 tb/tb_memory_cmd_sched.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/memory_cmd_sched.sv
// Command scheduler and round sequencer for the memory-game datapath.
// Debounces the board buttons into single-cycle, mutually exclusive commands, and sequences
// game start, the timed board-reveal phase and game-over acknowledgement.
module memory_cmd_sched #(
  parameter int unsigned REVEAL_CYCLES  = 100_000_000,
  parameter int unsigned LOCKOUT_CYCLES = 1_000_000,
  parameter int unsigned CMD_GAP        = 2
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic BtnR,
  input  logic BtnL,
  input  logic BtnU,
  input  logic BtnD,
  input  logic BtnS,
  input  logic Start,
  input  logic Ack,
  input  logic GamePlay,
  input  logic GameGen,
  input  logic GameLose,
  output logic GoStart,
  output logic Right,
  output logic Left,
  output logic Up,
  output logic Down,
  output logic Select,
  output logic ShowBoard,
  output logic Armed,
  output logic Qidle,
  output logic Qlaunch,
  output logic Qwait,
  output logic Qreveal,
  output logic Qarmed,
  output logic Qover
);

  localparam int unsigned RevW  = $clog2(REVEAL_CYCLES + 1);
  localparam int unsigned LockW = $clog2(LOCKOUT_CYCLES + 1);
  localparam int unsigned GapW  = $clog2(CMD_GAP + 1);

  localparam logic [RevW-1:0]  RevLoad  = RevW'(REVEAL_CYCLES - 1);
  localparam logic [LockW-1:0] LockLoad = LockW'(LOCKOUT_CYCLES - 1);
  localparam logic [GapW-1:0]  GapLoad  = GapW'(CMD_GAP - 1);

  typedef enum logic [2:0] {
    StIdle, StLaunch, StWaitPlay, StReveal, StArmed, StOver
  } state_e;

  state_e                  state_q, state_d;
  logic [RevW-1:0]         rev_q, rev_d;
  logic [GapW-1:0]         gap_q, gap_d;
  logic [4:0][LockW-1:0]   lock_q, lock_d;
  logic [4:0]              btn_q, pend_q, pend_d, cmd_q, cmd_d;
  logic                    go_start_q, go_start_d;
  logic                    ack_q;

  // Bit order everywhere: 0=R, 1=L, 2=U, 3=D, 4=S (index order is also priority order).
  logic [4:0] btn_in, btn_rise, accept, grant;
  logic       armed, stay_armed, issue;

  assign btn_in   = {BtnS, BtnD, BtnU, BtnL, BtnR};
  assign btn_rise = btn_in & ~btn_q;
  assign armed    = (state_q == StArmed);

  // Round sequencing and reveal countdown
  always_comb begin
    state_d    = state_q;
    rev_d      = rev_q;
    go_start_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          state_d    = StLaunch;
          go_start_d = 1'b1;
        end
      end
      StLaunch: state_d = StWaitPlay;
      StWaitPlay: begin
        if (GamePlay) begin
          state_d = StReveal;
          rev_d   = RevLoad;
        end
      end
      StReveal: begin
        if (rev_q == '0) state_d = StArmed;
        else             rev_d   = rev_q - RevW'(1);
      end
      StArmed: begin
        // Losing takes precedence over a cleared round.
        if (GameLose)     state_d = StOver;
        else if (GameGen) state_d = StWaitPlay;
      end
      StOver: begin
        // The game's LOSE state leaves on Start, so the ack edge also pulses GoStart.
        if (Ack && !ack_q) begin
          state_d    = StIdle;
          go_start_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign stay_armed = armed && (state_d == StArmed);
  assign grant      = pend_q & (~pend_q + 5'd1);
  assign issue      = armed && (gap_q == '0) && (|pend_q);

  // Per-button lockout, pending-command latch and fixed-priority issue
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      accept[i] = btn_rise[i] && (lock_q[i] == '0) && armed;
      if (accept[i])            lock_d[i] = LockLoad;
      else if (lock_q[i] != '0) lock_d[i] = lock_q[i] - LockW'(1);
      else                      lock_d[i] = lock_q[i];
    end
    // A fresh accept on a bit being issued this cycle wins over the clear.
    pend_d = (pend_q & ~(issue ? grant : 5'b0)) | accept;
    cmd_d  = issue ? grant : 5'b0;
    if (!stay_armed)      gap_d = '0;
    else if (issue)       gap_d = GapLoad;
    else if (gap_q != '0) gap_d = gap_q - GapW'(1);
    else                  gap_d = gap_q;
    if (!stay_armed) pend_d = '0;
  end

  // State and datapath registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= StIdle;
      rev_q      <= '0;
      gap_q      <= '0;
      lock_q     <= '0;
      btn_q      <= '0;
      pend_q     <= '0;
      cmd_q      <= '0;
      go_start_q <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rev_q      <= rev_d;
      gap_q      <= gap_d;
      lock_q     <= lock_d;
      btn_q      <= btn_in;
      pend_q     <= pend_d;
      cmd_q      <= cmd_d;
      go_start_q <= go_start_d;
      ack_q      <= Ack;
    end
  end

  assign GoStart   = go_start_q;
  assign Right     = cmd_q[0];
  assign Left      = cmd_q[1];
  assign Up        = cmd_q[2];
  assign Down      = cmd_q[3];
  assign Select    = cmd_q[4];
  assign ShowBoard = (state_q == StReveal);
  assign Armed     = armed;
  assign Qidle     = (state_q == StIdle);
  assign Qlaunch   = (state_q == StLaunch);
  assign Qwait     = (state_q == StWaitPlay);
  assign Qreveal   = (state_q == StReveal);
  assign Qarmed    = armed;
  assign Qover     = (state_q == StOver);

endmodule

// File: tb/tb_memory_cmd_sched.sv
// Directed self-checking bench for memory_cmd_sched with short reveal/lockout/gap lengths.
module tb_memory_cmd_sched;

  logic Clk = 1'b0;
  logic Reset_n;
  logic BtnR, BtnL, BtnU, BtnD, BtnS, Start, Ack, GamePlay, GameGen, GameLose;
  logic GoStart, Right, Left, Up, Down, Select, ShowBoard, Armed;
  logic Qidle, Qlaunch, Qwait, Qreveal, Qarmed, Qover;

  memory_cmd_sched #(
    .REVEAL_CYCLES (4),
    .LOCKOUT_CYCLES(8),
    .CMD_GAP       (2)
  ) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .BtnR     (BtnR),
    .BtnL     (BtnL),
    .BtnU     (BtnU),
    .BtnD     (BtnD),
    .BtnS     (BtnS),
    .Start    (Start),
    .Ack      (Ack),
    .GamePlay (GamePlay),
    .GameGen  (GameGen),
    .GameLose (GameLose),
    .GoStart  (GoStart),
    .Right    (Right),
    .Left     (Left),
    .Up       (Up),
    .Down     (Down),
    .Select   (Select),
    .ShowBoard(ShowBoard),
    .Armed    (Armed),
    .Qidle    (Qidle),
    .Qlaunch  (Qlaunch),
    .Qwait    (Qwait),
    .Qreveal  (Qreveal),
    .Qarmed   (Qarmed),
    .Qover    (Qover)
  );

  always #5 Clk = ~Clk;

  // cmds bit order: 0=R 1=L 2=U 3=D 4=S ; qs bit order: idle, launch, wait, reveal, armed, over
  logic [4:0] cmds;
  logic [5:0] qs;
  assign cmds = {Select, Down, Up, Left, Right};
  assign qs   = {Qover, Qarmed, Qreveal, Qwait, Qlaunch, Qidle};

  localparam logic [5:0] SIdle = 6'b000001, SLaunch = 6'b000010, SWait = 6'b000100;
  localparam logic [5:0] SOver = 6'b100000;

  int checks = 0;
  int errors = 0;
  int cnt_cmd [5] = '{0, 0, 0, 0, 0};
  int base_r;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Count command pulses and check they never overlap.
  always @(negedge Clk) begin
    if (Reset_n === 1'b1) begin
      for (int i = 0; i < 5; i++) cnt_cmd[i] += int'(cmds[i]);
      chk("cmd_onehot0", 32'($countones(cmds) <= 1), 32'd1);
    end
  end

  initial begin
    Reset_n = 1'b0;
    {BtnR, BtnL, BtnU, BtnD, BtnS} = '0;
    {Start, Ack, GamePlay, GameGen, GameLose} = '0;

    // 1. Reset and start
    #2;
    chk("reset_state", 32'(qs), 32'(SIdle));
    chk("reset_outs", 32'({GoStart, cmds, ShowBoard, Armed}), 32'd0);
    #10 Reset_n = 1'b1;
    tick();
    chk("idle_after_reset", 32'(qs), 32'(SIdle));
    Start = 1'b1;
    tick();
    chk("launch_gostart", 32'(GoStart), 32'd1);
    chk("launch_state", 32'(qs), 32'(SLaunch));
    Start = 1'b0;
    tick();
    chk("gostart_single", 32'(GoStart), 32'd0);
    chk("waitplay_state", 32'(qs), 32'(SWait));
    GamePlay = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      GamePlay = 1'b0;
      chk("reveal_showboard", 32'({ShowBoard, Armed}), 32'b10);
      if (i == 1) BtnL = 1'b1;  // press during reveal, held into ARMED
    end
    tick();
    chk("armed_after_reveal", 32'({ShowBoard, Armed}), 32'b01);
    repeat (3) tick();
    BtnL = 1'b0;
    repeat (3) tick();
    chk("reveal_mask_left", 32'(cnt_cmd[1]), 32'd0);

    // 2. Single press, hold, lockout
    base_r = cnt_cmd[0];
    BtnR = 1'b1;
    tick();
    chk("right_lat1", 32'(cmds), 32'd0);
    tick();
    chk("right_lat2", 32'(cmds), 32'b00001);
    repeat (18) tick();
    chk("hold_one_right", 32'(cnt_cmd[0] - base_r), 32'd1);
    BtnR = 1'b0;
    repeat (4) tick();
    BtnR = 1'b1;
    tick();
    tick();
    chk("repress_right", 32'(cmds), 32'b00001);
    BtnR = 1'b0;
    tick();
    BtnR = 1'b1;  // edge inside lockout: discarded
    tick();
    tick();
    chk("lockout_discard", 32'(cmds), 32'd0);
    BtnR = 1'b0;
    repeat (3) tick();
    chk("right_total", 32'(cnt_cmd[0] - base_r), 32'd2);
    repeat (10) tick();

    // 3. Simultaneous press, priority and gap
    {BtnR, BtnU, BtnS} = 3'b111;
    tick();
    chk("multi_t1", 32'(cmds), 32'd0);
    tick();
    chk("multi_r", 32'(cmds), 32'b00001);
    {BtnR, BtnU, BtnS} = 3'b000;
    tick();
    chk("multi_gap1", 32'(cmds), 32'd0);
    tick();
    chk("multi_u", 32'(cmds), 32'b00100);
    tick();
    chk("multi_gap2", 32'(cmds), 32'd0);
    tick();
    chk("multi_s", 32'(cmds), 32'b10000);
    tick();
    chk("multi_done", 32'(cmds), 32'd0);
    repeat (10) tick();

    // 5. Round cleared drops pending commands
    {BtnR, BtnL, BtnD} = 3'b111;
    tick();
    {BtnR, BtnL, BtnD} = 3'b000;
    tick();
    chk("gen_first_r", 32'(cmds), 32'b00001);
    GameGen = 1'b1;
    tick();
    chk("gen_to_wait", 32'(qs), 32'(SWait));
    GameGen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wait_no_cmd", 32'(cmds), 32'd0);
    end
    GamePlay = 1'b1;
    tick();
    GamePlay = 1'b0;
    chk("reveal_rerun", 32'({ShowBoard, Armed}), 32'b10);
    repeat (3) tick();
    tick();
    chk("rearmed", 32'({ShowBoard, Armed}), 32'b01);
    repeat (4) tick();
    chk("pending_cleared_l", 32'(cnt_cmd[1]), 32'd0);
    chk("pending_cleared_d", 32'(cnt_cmd[3]), 32'd0);

    // 6. Game over and restart
    GameLose = 1'b1;
    GameGen  = 1'b1;
    tick();
    chk("lose_wins", 32'(qs), 32'(SOver));
    GameLose = 1'b0;
    GameGen  = 1'b0;
    tick();
    chk("over_no_gostart", 32'({GoStart, qs}), 32'({1'b0, SOver}));
    Ack = 1'b1;
    tick();
    chk("ack_gostart", 32'({GoStart, qs}), 32'({1'b1, SIdle}));
    tick();
    chk("ack_single", 32'({GoStart, qs}), 32'({1'b0, SIdle}));
    tick();
    chk("ack_held", 32'(GoStart), 32'd0);
    Ack = 1'b0;

    // Asynchronous reset in REVEAL
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    GamePlay = 1'b1;
    tick();
    GamePlay = 1'b0;
    chk("reveal_before_rst", 32'(ShowBoard), 32'd1);
    tick();
    #2 Reset_n = 1'b0;
    #1;
    chk("async_rst_state", 32'(qs), 32'(SIdle));
    chk("async_rst_show", 32'(ShowBoard), 32'd0);
    #5 Reset_n = 1'b1;
    tick();
    chk("idle_after_rst", 32'(qs), 32'(SIdle));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
